ctrl_mailbox: RTL and testbench

CTRL_MAILBOX -- requirements
Module: ctrl_mailbox

---
 rtl/ctrl_mailbox_pkg.sv | 38 +++
 rtl/ctrl_mailbox_if.sv | 24 ++
 rtl/ctrl_mailbox_filter.sv | 85 ++++++++
 rtl/ctrl_mailbox.sv | 117 +++++++++++
 tb/tb_ctrl_mailbox.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_mailbox_pkg.sv
// rtl/ctrl_mailbox_pkg.sv - register offsets, bit positions, response fields and state enum for ctrl_mailbox
package ctrl_mailbox_pkg;

    localparam logic [3:0] ADDR_RXDATA = 4'h0;
    localparam logic [3:0] ADDR_TXDATA = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    localparam int STATUS_RX_VALID_BIT = 0;
    localparam int STATUS_OVF_BIT      = 1;
    localparam int CTRL_IE_BIT         = 0;

    localparam int HOST_TOG_BIT    = 31;
    localparam int RESP_ACK_BIT    = 31;
    localparam int RESP_TX_TOG_BIT = 30;
    localparam int RESP_TX_DATA_W  = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FULL   = 2'd2
    } mbox_state_t;

    // Bits [29:24] of the response word always read as zero.
    function automatic logic [31:0] resp_word(
        input logic                      ack,
        input logic                      tx_tog,
        input logic [RESP_TX_DATA_W-1:0] tx_data
    );
        logic [31:0] w;
        w                        = '0;
        w[RESP_ACK_BIT]          = ack;
        w[RESP_TX_TOG_BIT]       = tx_tog;
        w[RESP_TX_DATA_W-1:0]    = tx_data;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_mailbox_if.sv
// rtl/ctrl_mailbox_if.sv - APB register bus for ctrl_mailbox
interface ctrl_mailbox_if;
    import ctrl_mailbox_pkg::*;

    logic [3:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/ctrl_mailbox_filter.sv
// rtl/ctrl_mailbox_filter.sv - host toggle detect and stability filter; holds one message until popped
module ctrl_mailbox_filter
    import ctrl_mailbox_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [31:0] host_word,
    input  logic        pop,
    output logic        rx_valid,
    output logic        capture,
    output logic [30:0] capture_data,
    output logic        last_tog,
    output logic        ovf_event
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    mbox_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] sample, sample_nxt;
    logic        last_tog_nxt;
    logic        prev_tog;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            cnt      <= '0;
            sample   <= '0;
            last_tog <= 1'b0;
            prev_tog <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sample   <= sample_nxt;
            last_tog <= last_tog_nxt;
            prev_tog <= host_word[HOST_TOG_BIT];
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sample_nxt   = sample;
        last_tog_nxt = last_tog;
        capture      = 1'b0;
        ovf_event    = 1'b0;
        case (state)
            IDLE: begin
                if (host_word[HOST_TOG_BIT] != last_tog) begin
                    sample_nxt = host_word;
                    cnt_nxt    = '0;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                // The sample register has been seen STABLE_CYCLES times once cnt hits CNT_LAST.
                if (host_word[HOST_TOG_BIT] == last_tog) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    capture      = 1'b1;
                    last_tog_nxt = sample[HOST_TOG_BIT];
                    state_nxt    = FULL;
                end else if (host_word == sample) begin
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    sample_nxt = host_word;
                    cnt_nxt    = '0;
                end
            end
            FULL: begin
                ovf_event = host_word[HOST_TOG_BIT] != prev_tog;
                if (pop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_valid     = state == FULL;
    assign capture_data = sample[30:0];

endmodule

// File: rtl/ctrl_mailbox.sv
// rtl/ctrl_mailbox.sv - host/SoC mailbox with APB registers; CTRL_MAILBOX_IRQ_EN enables the ie bit and irq
module ctrl_mailbox
    import ctrl_mailbox_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic          soc_clk,
    input  logic          aresetn,
    input  logic [31:0]   dat_ctrl_to_cfg,
    output logic [31:0]   dat_cfg_to_ctrl,
    ctrl_mailbox_if.slave apb,
    output logic          irq
);

    logic        wr_access;
    logic        rd_access;
    logic        pop;
    logic        ovf_clr;
    logic        rx_valid;
    logic        capture;
    logic [30:0] capture_data;
    logic        last_tog;
    logic        ovf_event;
    logic [30:0] rx_data;
    logic        ack;
    logic        tx_tog;
    logic [23:0] tx_data;
    logic        ovf;
    logic        unused_pwdata;

    assign wr_access = apb.psel & apb.penable & apb.pwrite;
    assign rd_access = apb.psel & apb.penable & ~apb.pwrite;
    assign pop       = rd_access && (apb.paddr == ADDR_RXDATA) && rx_valid;
    assign ovf_clr   = wr_access && (apb.paddr == ADDR_STATUS) && apb.pwdata[STATUS_OVF_BIT];

    assign unused_pwdata = ^apb.pwdata[31:24];

    ctrl_mailbox_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk          (soc_clk),
        .aresetn      (aresetn),
        .host_word    (dat_ctrl_to_cfg),
        .pop          (pop),
        .rx_valid     (rx_valid),
        .capture      (capture),
        .capture_data (capture_data),
        .last_tog     (last_tog),
        .ovf_event    (ovf_event)
    );

    always_ff @(posedge soc_clk or negedge aresetn) begin
        if (!aresetn) begin
            rx_data <= '0;
            ack     <= 1'b0;
            tx_tog  <= 1'b0;
            tx_data <= '0;
            ovf     <= 1'b0;
        end else begin
            if (capture) begin
                rx_data <= capture_data;
            end
            if (pop) begin
                ack <= last_tog;
            end
            if (wr_access && (apb.paddr == ADDR_TXDATA)) begin
                tx_data <= apb.pwdata[23:0];
                tx_tog  <= ~tx_tog;
            end
            // A fresh overflow beats a simultaneous write-1-to-clear.
            if (ovf_event) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef CTRL_MAILBOX_IRQ_EN
    logic ie;

    always_ff @(posedge soc_clk or negedge aresetn) begin
        if (!aresetn) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_access && (apb.paddr == ADDR_CTRL)) begin
                ie <= apb.pwdata[CTRL_IE_BIT];
            end
            irq <= ie & (rx_valid | ovf);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        apb.prdata = '0;
        case (apb.paddr)
            ADDR_RXDATA: apb.prdata = {1'b0, rx_data};
            ADDR_TXDATA: apb.prdata = {8'h00, tx_data};
            ADDR_STATUS: begin
                apb.prdata[STATUS_RX_VALID_BIT] = rx_valid;
                apb.prdata[STATUS_OVF_BIT]      = ovf;
            end
`ifdef CTRL_MAILBOX_IRQ_EN
            ADDR_CTRL:   apb.prdata[CTRL_IE_BIT] = ie;
`endif
            default:     apb.prdata = '0;
        endcase
    end

    assign apb.pready      = 1'b1;
    assign apb.pslverr     = 1'b0;
    assign dat_cfg_to_ctrl = resp_word(ack, tx_tog, tx_data);

endmodule

// File: tb/tb_ctrl_mailbox.sv
// tb/tb_ctrl_mailbox.sv - randomized self-checking bench for ctrl_mailbox against a run-length reference model
`timescale 1ns/1ps
module tb_ctrl_mailbox;

    localparam int STABLE = 4;
`ifdef CTRL_MAILBOX_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        soc_clk   = 1'b0;
    logic        aresetn   = 1'b0;
    logic [31:0] host_word = 32'h0;
    logic [31:0] resp;
    logic        irq;

    ctrl_mailbox_if apb();

    ctrl_mailbox #(
        .STABLE_CYCLES(STABLE)
    ) dut (
        .soc_clk         (soc_clk),
        .aresetn         (aresetn),
        .dat_ctrl_to_cfg (host_word),
        .dat_cfg_to_ctrl (resp),
        .apb             (apb),
        .irq             (irq)
    );

    always #5 soc_clk = ~soc_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a message is taken once STABLE identical samples with a new
    // toggle have been seen while the mailbox is empty.
    bit          m_full, m_last_tog, m_ack, m_tx_tog, m_ovf, m_ie, m_irq, m_prev_tog;
    logic [30:0] m_rx;
    logic [23:0] m_tx;
    logic [31:0] m_run_word;
    int          m_run;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_last_tog = 0; m_ack = 0; m_tx_tog = 0; m_ovf = 0;
        m_ie = 0; m_irq = 0; m_prev_tog = 0;
        m_rx = '0; m_tx = '0; m_run_word = '0; m_run = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'h0:    return {1'b0, m_rx};
            4'h4:    return {8'h00, m_tx};
            4'h8:    return {30'h0, m_ovf, m_full};
            4'hC:    return IRQ_EN ? {31'h0, m_ie} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        bit wr, rd, pop, ovf_ev, cap, irq_next;
        if (!aresetn) begin
            model_reset();
            return;
        end
        wr       = apb.psel && apb.penable && apb.pwrite;
        rd       = apb.psel && apb.penable && !apb.pwrite;
        pop      = rd && apb.paddr == 4'h0 && m_full;
        ovf_ev   = m_full && (host_word[31] != m_prev_tog);
        irq_next = IRQ_EN && m_ie && (m_full || m_ovf);
        cap      = 0;
        if (!m_full) begin
            if (host_word[31] == m_last_tog) m_run = 0;
            else if (m_run == STABLE) cap = 1;
            else if (m_run > 0 && host_word == m_run_word) m_run++;
            else begin
                m_run      = 1;
                m_run_word = host_word;
            end
        end
        if (pop) begin
            m_ack  = m_last_tog;
            m_full = 0;
            m_run  = 0;
        end
        if (cap) begin
            m_rx       = m_run_word[30:0];
            m_last_tog = m_run_word[31];
            m_full     = 1;
            m_run      = 0;
        end
        if (wr && apb.paddr == 4'h4) begin
            m_tx     = apb.pwdata[23:0];
            m_tx_tog = ~m_tx_tog;
        end
        if (ovf_ev) m_ovf = 1;
        else if (wr && apb.paddr == 4'h8 && apb.pwdata[1]) m_ovf = 0;
        if (IRQ_EN && wr && apb.paddr == 4'hC) m_ie = apb.pwdata[0];
        m_irq      = irq_next;
        m_prev_tog = host_word[31];
    endtask

    task automatic step();
        model_edge();
        @(posedge soc_clk);
        #1;
        expect_eq("resp", resp, {m_ack, m_tx_tog, 6'h00, m_tx});
        expect_eq("irq", 32'(irq), 32'(m_irq));
        expect_eq("prdata", apb.prdata, m_read(apb.paddr));
    endtask

    task automatic apb_idle();
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        apb.paddr = a; apb.pwdata = d; apb.pwrite = 1; apb.psel = 1; apb.penable = 0;
        step();
        apb.penable = 1;
        step();
        apb_idle();
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        apb.paddr = a; apb.pwrite = 0; apb.psel = 1; apb.penable = 0;
        step();
        apb.penable = 1;
        #1;
        d = apb.prdata;
        step();
        apb_idle();
    endtask

    task automatic do_reset();
        aresetn = 0;
        apb_idle();
        #1;
        model_reset();
        expect_eq("rst_resp", resp, 32'h0);
        expect_eq("rst_irq", 32'(irq), 32'h0);
        step();
        step();
        aresetn = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  addrs [4];
        int          ph;
        bit          tog;
        logic [30:0] pay;

        addrs = '{4'h0, 4'h4, 4'h8, 4'hC};
        apb.paddr = 4'h0; apb.pwdata = 32'h0;
        apb_idle();
        model_reset();

        do_reset();
        foreach (addrs[i]) begin
            apb.paddr = addrs[i];
            #1;
            expect_eq("rst_prdata", apb.prdata, 32'h0);
        end
        expect_eq("pready", 32'(apb.pready), 32'h1);
        expect_eq("pslverr", 32'(apb.pslverr), 32'h0);

        // Single clean message, first-capture latency and ack.
        do_reset();
        apb.paddr = 4'h8;
        host_word = 32'h8000_1234;
        for (int k = 1; k <= 10; k++) begin
            step();
            expect_eq($sformatf("d1_rxv_c%0d", k), 32'(apb.prdata[0]), 32'(k >= STABLE + 1));
        end
        apb_read(4'h0, d);
        expect_eq("d1_rxdata", d, 32'h0000_1234);
        expect_eq("d1_ack", 32'(resp[31]), 32'h1);

        // Bounce: counter restarts on the new word.
        do_reset();
        apb.paddr = 4'h8;
        host_word = 32'h8000_0001;
        step();
        step();
        host_word = 32'h8000_0002;
        for (int k = 1; k <= STABLE + 1; k++) begin
            step();
            expect_eq($sformatf("d2_rxv_k%0d", k), 32'(apb.prdata[0]), 32'(k == STABLE + 1));
        end

        // Overflow while full, write-1-to-clear, then the pending word after the pop.
        host_word = 32'h0000_0055;
        step();
        apb_read(4'h8, d);
        expect_eq("d3_status_ovf", d, 32'h3);
        apb_write(4'h8, 32'h2);
        apb_read(4'h8, d);
        expect_eq("d3_status_clr", d, 32'h1);
        apb_read(4'h0, d);
        expect_eq("d2_rxdata", d, 32'h0000_0002);
        apb.paddr = 4'h8;
        for (int k = 1; k <= STABLE + 1; k++) begin
            step();
            expect_eq($sformatf("d3_rxv_k%0d", k), 32'(apb.prdata[0]), 32'(k == STABLE + 1));
        end
        apb_read(4'h0, d);
        expect_eq("d3_rxdata", d, 32'h0000_0055);
        expect_eq("d3_ack", 32'(resp[31]), 32'h0);

        // TX data and toggle.
        apb_write(4'h4, 32'h00AB_CDEF);
        expect_eq("d4_resp1", resp, 32'h40AB_CDEF);
        apb_write(4'h4, 32'h00AB_CDEF);
        expect_eq("d4_resp2", resp, 32'h00AB_CDEF);
        apb_read(4'h4, d);
        expect_eq("d4_txdata", d, 32'h00AB_CDEF);

        // Interrupt timing.
        apb_write(4'hC, 32'h1);
        apb_read(4'hC, d);
        expect_eq("d5_ctrl", d, 32'(IRQ_EN));
        apb.paddr = 4'h8;
        host_word = 32'h8000_0077;
        for (int k = 1; k <= STABLE + 1; k++) step();
        expect_eq("d5_rxv", 32'(apb.prdata[0]), 32'h1);
        expect_eq("d5_irq_lat", 32'(irq), 32'h0);
        step();
        expect_eq("d5_irq_rise", 32'(irq), 32'(IRQ_EN));
        apb_read(4'h0, d);
        expect_eq("d5_rxdata", d, 32'h0000_0077);
        expect_eq("d5_irq_pop", 32'(irq), 32'(IRQ_EN));
        step();
        expect_eq("d5_irq_fall", 32'(irq), 32'h0);
        apb_write(4'hC, 32'h0);

        // Reset mid-settle discards the message; the held word is taken again after release.
        do_reset();
        apb.paddr = 4'h8;
        host_word = 32'h8000_0009;
        step();
        step();
        do_reset();
        expect_eq("d6_rxv_rst", 32'(apb.prdata[0]), 32'h0);
        expect_eq("d6_ack_rst", 32'(resp[31]), 32'h0);
        for (int k = 1; k <= STABLE + 1; k++) begin
            step();
            expect_eq($sformatf("d6_rxv_k%0d", k), 32'(apb.prdata[0]), 32'(k == STABLE + 1));
        end
        apb_read(4'h0, d);
        expect_eq("d6_rxdata", d, 32'h0000_0009);

        // Random host traffic, APB accesses and occasional resets against the model.
        ph = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                tog = ($urandom_range(0, 3) == 0) ? host_word[31] : ~host_word[31];
                pay = ($urandom_range(0, 1) == 1) ? 31'($urandom_range(0, 3)) : 31'($urandom);
                host_word = {tog, pay};
            end
            if (ph == 0 && $urandom_range(0, 2) == 0) begin
                apb.paddr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : addrs[$urandom_range(0, 3)];
                apb.pwrite  = $urandom_range(0, 1) == 1;
                apb.pwdata  = $urandom;
                apb.psel    = 1;
                apb.penable = 0;
                ph = 1;
            end else if (ph == 1) begin
                apb.penable = 1;
                ph = 2;
            end else if (ph == 2) begin
                apb_idle();
                ph = 0;
            end
            if (!aresetn) aresetn = 1;
            else if ($urandom_range(0, 799) == 0) aresetn = 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
